// File: rtl/nfc_cmd_seq.sv
// NFC command sequencer: on one host request, writes the 13-entry NFC register set
// for a flash operation, then polls the status register until not busy or poll limit.
module nfc_cmd_seq #(
  parameter logic [8:0] CMD_OFS      = 9'h000,
  parameter logic [8:0] ROW0_OFS     = 9'h004,
  parameter logic [8:0] COL0_OFS     = 9'h008,
  parameter logic [8:0] ADDR_CNT_OFS = 9'h00C,
  parameter logic [8:0] TIMING_OFS   = 9'h00D,
  parameter logic [8:0] TRN_CNT0_OFS = 9'h00E,
  parameter logic [8:0] CTRL0_OFS    = 9'h00F,
  parameter logic [8:0] STATUS_OFS   = 9'h010,
  parameter int         BUSY_BIT     = 0,
  parameter int         POLL_GAP     = 8,
  parameter int         POLL_MAX     = 1024
) (
  input  logic        nfc_clk,
  input  logic        rst_nfc,
  input  logic        seq_req,
  input  logic [7:0]  seq_cmd,
  input  logic [31:0] seq_row,
  input  logic [31:0] seq_col,
  input  logic [7:0]  seq_addr_cnt,
  input  logic [7:0]  seq_timing,
  input  logic [7:0]  seq_trn_cnt,
  input  logic [7:0]  seq_ctrl0,
  output logic        seq_rdy,
  output logic        seq_done,
  output logic        seq_err,
  output logic [8:0]  reg_addr,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [7:0]  reg_din,
  input  logic [7:0]  reg_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_GAP, S_POLL_WAIT, S_POLL_RD, S_POLL_CHK, S_DONE
  } state_t;

  localparam logic [3:0]  LAST_ITEM  = 4'd12;
  localparam logic [7:0]  GAP_LAST   = 8'(POLL_GAP - 1);
  localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

  state_t      state, state_nxt;
  logic [3:0]  item, item_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic [15:0] poll_cnt, poll_cnt_nxt;
  logic        err_q, err_nxt;
  logic        accept;

  logic [7:0]  cmd_q, addr_cnt_q, timing_q, trn_cnt_q, ctrl0_q;
  logic [31:0] row_q, col_q;
  logic [8:0]  item_addr;
  logic [7:0]  item_data;

  // Only the busy bit of the status byte carries meaning.
  logic unused_status;
  assign unused_status = ^reg_dout;

  assign accept = seq_req && (state == S_IDLE);

  // NOTE: the request capture registers carry no reset; they are only read in states
  // reachable after an accept has loaded them, so a reset value would never be observed.
  always_ff @(posedge nfc_clk) begin
    if (accept) begin
      cmd_q      <= seq_cmd;
      row_q      <= seq_row;
      col_q      <= seq_col;
      addr_cnt_q <= seq_addr_cnt;
      timing_q   <= seq_timing;
      trn_cnt_q  <= seq_trn_cnt;
      ctrl0_q    <= seq_ctrl0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples the
  // pre-edge values; the combinational block below uses blocking assignments.
  always_ff @(posedge nfc_clk or posedge rst_nfc) begin
    if (rst_nfc) begin
      state    <= S_IDLE;
      item     <= '0;
      gap_cnt  <= '0;
      poll_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      item     <= item_nxt;
      gap_cnt  <= gap_cnt_nxt;
      poll_cnt <= poll_cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  // Register write list, in issue order.
  always_comb begin
    item_addr = '0;
    item_data = '0;
    case (item)
      4'd0:  begin item_addr = CMD_OFS;              item_data = cmd_q;        end
      4'd1:  begin item_addr = ROW0_OFS;             item_data = row_q[7:0];   end
      4'd2:  begin item_addr = ROW0_OFS + 9'd1;      item_data = row_q[15:8];  end
      4'd3:  begin item_addr = ROW0_OFS + 9'd2;      item_data = row_q[23:16]; end
      4'd4:  begin item_addr = ROW0_OFS + 9'd3;      item_data = row_q[31:24]; end
      4'd5:  begin item_addr = COL0_OFS;             item_data = col_q[7:0];   end
      4'd6:  begin item_addr = COL0_OFS + 9'd1;      item_data = col_q[15:8];  end
      4'd7:  begin item_addr = COL0_OFS + 9'd2;      item_data = col_q[23:16]; end
      4'd8:  begin item_addr = COL0_OFS + 9'd3;      item_data = col_q[31:24]; end
      4'd9:  begin item_addr = ADDR_CNT_OFS;         item_data = addr_cnt_q;   end
      4'd10: begin item_addr = TIMING_OFS;           item_data = timing_q;     end
      4'd11: begin item_addr = TRN_CNT0_OFS;         item_data = trn_cnt_q;    end
      4'd12: begin item_addr = CTRL0_OFS;            item_data = ctrl0_q;      end
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt    = state;
    item_nxt     = item;
    gap_cnt_nxt  = gap_cnt;
    poll_cnt_nxt = poll_cnt;
    err_nxt      = err_q;
    seq_rdy      = 1'b0;
    seq_done     = 1'b0;
    reg_addr     = '0;
    reg_din      = '0;
    reg_wr       = 1'b0;
    reg_rd       = 1'b0;

    case (state)
      S_IDLE: begin
        seq_rdy = 1'b1;
        if (accept) begin
          state_nxt    = S_WR;
          item_nxt     = '0;
          gap_cnt_nxt  = '0;
          poll_cnt_nxt = '0;
          err_nxt      = 1'b0;
        end
      end
      S_WR: begin
        reg_wr    = 1'b1;
        reg_addr  = item_addr;
        reg_din   = item_data;
        state_nxt = (item == LAST_ITEM) ? S_POLL_WAIT : S_WR_GAP;
      end
      S_WR_GAP: begin
        item_nxt  = item + 4'd1;
        state_nxt = S_WR;
      end
      S_POLL_WAIT: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nxt = '0;
          state_nxt   = S_POLL_RD;
        end else begin
          gap_cnt_nxt = gap_cnt + 8'd1;
        end
      end
      S_POLL_RD: begin
        reg_rd    = 1'b1;
        reg_addr  = STATUS_OFS;
        state_nxt = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        // Read data arrives the cycle after the read strobe.
        if (!reg_dout[BUSY_BIT]) begin
          state_nxt = S_DONE;
        end else begin
          poll_cnt_nxt = poll_cnt + 16'd1;
          if (poll_cnt_nxt == POLL_LIMIT) begin
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_POLL_WAIT;
          end
        end
      end
      S_DONE: begin
        seq_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign seq_err = err_q;

endmodule

// File: tb/tb_nfc_cmd_seq.sv
// Scoreboard bench for nfc_cmd_seq: the driver predicts every register strobe and
// completion from the operation rules; a monitor pops and compares as the DUT acts.
module tb_nfc_cmd_seq;

  localparam int         G            = 8;
  localparam int         PMAX         = 4;
  localparam logic [8:0] CMD_OFS      = 9'h000;
  localparam logic [8:0] ROW0_OFS     = 9'h004;
  localparam logic [8:0] COL0_OFS     = 9'h008;
  localparam logic [8:0] ADDR_CNT_OFS = 9'h00C;
  localparam logic [8:0] TIMING_OFS   = 9'h00D;
  localparam logic [8:0] TRN_CNT0_OFS = 9'h00E;
  localparam logic [8:0] CTRL0_OFS    = 9'h00F;
  localparam logic [8:0] STATUS_OFS   = 9'h010;

  typedef enum int {EV_WR = 0, EV_RD = 1, EV_DONE = 2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         cyc;
    logic [8:0] addr;
    logic [7:0] data;
  } ev_t;

  logic        nfc_clk = 1'b0;
  logic        rst_nfc;
  logic        seq_req;
  logic [7:0]  seq_cmd, seq_addr_cnt, seq_timing, seq_trn_cnt, seq_ctrl0;
  logic [31:0] seq_row, seq_col;
  logic        seq_rdy, seq_done, seq_err;
  logic [8:0]  reg_addr;
  logic        reg_wr, reg_rd;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout = 8'h00;

  int  n_vec = 0;
  int  n_fail = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  // Driver-owned model state
  int txn_id = 0;
  int busy_cfg = 0;
  int err_clr_cyc = -1;
  int busy_from = 0;
  int busy_to = -1;
  int last_done = -1;

  // Monitor-owned model state
  bit err_exp = 1'b0;

  nfc_cmd_seq #(.POLL_GAP(G), .POLL_MAX(PMAX)) dut (
    .nfc_clk(nfc_clk), .rst_nfc(rst_nfc),
    .seq_req(seq_req), .seq_cmd(seq_cmd), .seq_row(seq_row), .seq_col(seq_col),
    .seq_addr_cnt(seq_addr_cnt), .seq_timing(seq_timing), .seq_trn_cnt(seq_trn_cnt),
    .seq_ctrl0(seq_ctrl0), .seq_rdy(seq_rdy), .seq_done(seq_done), .seq_err(seq_err),
    .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_din(reg_din),
    .reg_dout(reg_dout)
  );

  always #5 nfc_clk = ~nfc_clk;
  always @(posedge nfc_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_junk();
    seq_cmd      = 8'($urandom);
    seq_row      = $urandom;
    seq_col      = $urandom;
    seq_addr_cnt = 8'($urandom);
    seq_timing   = 8'($urandom);
    seq_trn_cnt  = 8'($urandom);
    seq_ctrl0    = 8'($urandom);
  endtask

  // Reference model: predicted strobe/completion events for one accepted request.
  function automatic int plan_txn(input int c, input logic [7:0] f_cmd,
                                  input logic [31:0] f_row, input logic [31:0] f_col,
                                  input logic [7:0] f_ac, input logic [7:0] f_tm,
                                  input logic [7:0] f_tr, input logic [7:0] f_c0,
                                  input int busy);
    logic [8:0] offs[13];
    logic [7:0] vals[13];
    ev_t ev;
    int n_rd;
    offs[0] = CMD_OFS; vals[0] = f_cmd;
    for (int i = 0; i < 4; i++) begin
      offs[1+i] = ROW0_OFS + 9'(i); vals[1+i] = f_row[8*i +: 8];
      offs[5+i] = COL0_OFS + 9'(i); vals[5+i] = f_col[8*i +: 8];
    end
    offs[9]  = ADDR_CNT_OFS; vals[9]  = f_ac;
    offs[10] = TIMING_OFS;   vals[10] = f_tm;
    offs[11] = TRN_CNT0_OFS; vals[11] = f_tr;
    offs[12] = CTRL0_OFS;    vals[12] = f_c0;
    for (int k = 0; k < 13; k++) begin
      ev.kind = EV_WR; ev.cyc = c + 1 + 2*k; ev.addr = offs[k]; ev.data = vals[k];
      exp_q.push_back(ev);
    end
    n_rd = (busy >= PMAX) ? PMAX : busy + 1;
    for (int j = 0; j < n_rd; j++) begin
      ev.kind = EV_RD; ev.cyc = c + 26 + G + j*(G+2); ev.addr = STATUS_OFS; ev.data = 8'h00;
      exp_q.push_back(ev);
    end
    ev.kind = EV_DONE; ev.cyc = c + 28 + G + (n_rd-1)*(G+2); ev.addr = 9'h000;
    ev.data = (busy >= PMAX) ? 8'h01 : 8'h00;
    exp_q.push_back(ev);
    return ev.cyc;
  endfunction

  // Holds seq_req high (with junk data) until accepted; returns the accept cycle.
  task automatic issue(input logic [7:0] f_cmd, input logic [31:0] f_row,
                       input logic [31:0] f_col, input logic [7:0] f_ac,
                       input logic [7:0] f_tm, input logic [7:0] f_tr,
                       input logic [7:0] f_c0, input int busy, input bit b2b,
                       output int acc);
    int waited = 0;
    bit got = 1'b0;
    int t_done;
    acc = -1;
    while (!got && waited < 500) begin
      @(negedge nfc_clk);
      seq_req = 1'b1;
      if (seq_rdy) begin
        seq_cmd = f_cmd; seq_row = f_row; seq_col = f_col; seq_addr_cnt = f_ac;
        seq_timing = f_tm; seq_trn_cnt = f_tr; seq_ctrl0 = f_c0;
        got = 1'b1;
      end else begin
        drive_junk();
        waited++;
      end
    end
    if (!got) begin
      check("accept_timeout", 32'(waited), 32'd0);
    end else begin
      acc = cyc;
      txn_id++;
      busy_cfg = busy;
      t_done = plan_txn(acc, f_cmd, f_row, f_col, f_ac, f_tm, f_tr, f_c0, busy);
      if (b2b) check("b2b_accept_cycle", 32'(acc), 32'(last_done + 1));
      err_clr_cyc = acc + 1;
      busy_from = acc + 1;
      busy_to = t_done;
      last_done = t_done;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge nfc_clk);
      seq_req = 1'b0;
      drive_junk();
    end
  endtask

  // NFC status responder: first busy_cfg polls of a request report busy.
  int         rsp_txn = -1;
  int         rsp_cnt = 0;
  bit         rsp_hold = 1'b0;
  logic [7:0] rsp_junk;
  always @(negedge nfc_clk) begin
    if (reg_rd) begin
      if (txn_id != rsp_txn) begin
        rsp_txn = txn_id;
        rsp_cnt = 0;
      end
      rsp_junk = 8'($urandom);
      reg_dout = (rsp_cnt < busy_cfg) ? (rsp_junk | 8'h01) : (rsp_junk & 8'hFE);
      rsp_cnt++;
      rsp_hold = 1'b1;
    end else if (rsp_hold) begin
      rsp_hold = 1'b0;
    end else begin
      reg_dout = 8'($urandom);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes or completes.
  ev_t      mon_ev;
  ev_kind_t act_kind;
  always @(negedge nfc_clk) begin
    if (!rst_nfc && mon_en) begin
      if (cyc == err_clr_cyc) err_exp = 1'b0;
      check("wr_rd_overlap", 32'(reg_wr & reg_rd), 32'd0);
      if (!reg_wr && !reg_rd) check("idle_bus", 32'({reg_addr, reg_din}), 32'd0);
      if (reg_wr || reg_rd || seq_done) begin
        act_kind = reg_wr ? EV_WR : (reg_rd ? EV_RD : EV_DONE);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_event at cycle %0d: got wr=%b rd=%b done=%b addr=0x%0h, want none",
                   cyc, reg_wr, reg_rd, seq_done, reg_addr);
        end else begin
          mon_ev = exp_q.pop_front();
          check("event_kind", 32'(act_kind), 32'(mon_ev.kind));
          check("event_cycle", 32'(cyc), 32'(mon_ev.cyc));
          if (mon_ev.kind == EV_WR) begin
            check("wr_addr", 32'(reg_addr), 32'(mon_ev.addr));
            check("wr_data", 32'(reg_din), 32'(mon_ev.data));
          end else if (mon_ev.kind == EV_RD) begin
            check("rd_addr", 32'(reg_addr), 32'(mon_ev.addr));
          end else begin
            err_exp = mon_ev.data[0];
            check("done_err", 32'(seq_err), 32'(mon_ev.data[0]));
          end
        end
      end
      check("seq_err_level", 32'(seq_err), 32'(err_exp));
      check("seq_rdy", 32'(seq_rdy), 32'(!(cyc >= busy_from && cyc <= busy_to)));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int w;
    rst_nfc = 1'b1;
    seq_req = 1'b0;
    drive_junk();
    #3;
    check("rst_seq_rdy", 32'(seq_rdy), 32'd1);
    check("rst_seq_done", 32'(seq_done), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_wr", 32'(reg_wr), 32'd0);
    check("rst_reg_rd", 32'(reg_rd), 32'd0);
    check("rst_reg_din", 32'(reg_din), 32'd0);
    repeat (3) @(negedge nfc_clk);
    rst_nfc = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Nominal, busy-then-ready, timeout
    issue(8'h70, 32'h55CC2200, 32'h00AA0302, 8'h1A, 8'h36, 8'h10, 8'hC9, 0, 1'b0, acc);
    idle(80);
    issue(8'($urandom), $urandom, $urandom, 8'($urandom), 8'($urandom), 8'($urandom),
          8'($urandom), 3, 1'b0, acc);
    idle(80);
    issue(8'($urandom), $urandom, $urandom, 8'($urandom), 8'($urandom), 8'($urandom),
          8'($urandom), 1000, 1'b0, acc);
    idle(80);

    // Reset during the write strobe of cycle 9
    issue(8'h60, 32'h01020304, 32'h05060708, 8'h05, 8'h11, 8'h22, 8'h80, 0, 1'b0, acc);
    idle(1);
    repeat (8) @(negedge nfc_clk);
    #2;
    rst_nfc = 1'b1;
    exp_q.delete();
    busy_to = -1;
    #1;
    check("midrst_reg_wr", 32'(reg_wr), 32'd0);
    check("midrst_reg_addr", 32'(reg_addr), 32'd0);
    check("midrst_reg_din", 32'(reg_din), 32'd0);
    check("midrst_seq_rdy", 32'(seq_rdy), 32'd1);
    repeat (3) @(negedge nfc_clk);
    rst_nfc = 1'b0;
    #1;
    check("post_rst_rdy", 32'(seq_rdy), 32'd1);
    idle(40);

    // Randomized back-to-back chain with seq_req held high throughout
    for (int i = 0; i < 20; i++) begin
      issue(8'($urandom), $urandom, $urandom, 8'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), int'($urandom_range(5, 0)), (i > 0), acc);
    end
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      idle(1);
      w++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/nfc_cmd_seq.md
# nfc_cmd_seq

Command sequencer sitting between the host/MIF side and the NFC register port. On a single host request it writes the full NFC register set for one flash operation, then polls the NFC status register until the operation completes or a poll limit expires. It drives the NFC register port as its sole master; nothing else may drive that port while the sequencer is busy.

## Interface

Parameters:
- CMD_OFS, 9'h000: NFC_IF_CMD register offset.
- ROW0_OFS, 9'h004: row address byte 0 offset; bytes 1..3 sit at +1..+3.
- COL0_OFS, 9'h008: column address byte 0 offset; bytes 1..3 sit at +1..+3.
- ADDR_CNT_OFS, 9'h00C: address-count register offset.
- TIMING_OFS, 9'h00D: timing configuration register offset.
- TRN_CNT0_OFS, 9'h00E: transfer-count register offset.
- CTRL0_OFS, 9'h00F: IF_CTRL0 (kick-off) register offset.
- STATUS_OFS, 9'h010: status register offset.
- BUSY_BIT, 0: status bit index meaning "NFC busy".
- POLL_GAP, 8: idle cycles between status polls (1..255).
- POLL_MAX, 1024: busy polls before timeout (1..65535).

Ports:
- nfc_clk, in, 1: sole clock.
- rst_nfc, in, 1: reset, asynchronous and active-high.
- seq_req, in, 1: start request; accepted only when seq_rdy=1.
- seq_cmd, in, 8: flash command byte.
- seq_row, in, 32: row address bytes 3..0.
- seq_col, in, 32: column address bytes 3..0.
- seq_addr_cnt, in, 8: address-count value.
- seq_timing, in, 8: timing configuration value.
- seq_trn_cnt, in, 8: transfer-count value.
- seq_ctrl0, in, 8: IF_CTRL0 value (written last, starts the NFC).
- seq_rdy, out, 1: idle, ready for a request.
- seq_done, out, 1: one-cycle completion pulse.
- seq_err, out, 1: timeout flag, valid with seq_done; holds until the next accept.
- reg_addr, out, 9: NFC register address.
- reg_wr, out, 1: NFC register write strobe.
- reg_rd, out, 1: NFC register read strobe.
- reg_din, out, 8: NFC register write data.
- reg_dout, in, 8: NFC register read data, valid the cycle after reg_rd.

## Operation

- On accept (seq_req & seq_rdy), all seq_* inputs are latched; later changes are ignored.
- States: IDLE, WR, WR_GAP, POLL_WAIT, POLL_RD, POLL_CHK, DONE.
- Write list, fixed order, index k=0..12: CMD; ROW0..ROW3 (seq_row[7:0] first); COL0..COL3 (seq_col[7:0] first); ADDR_CNT; TIMING; TRN_CNT0; CTRL0.
- WR: drive reg_addr/reg_din for item k with reg_wr=1 for exactly one cycle. WR_GAP: reg_wr=0, reg_addr=0, reg_din=0; k++. After k=12 go to POLL_WAIT.
- POLL_WAIT: count POLL_GAP cycles. POLL_RD: reg_addr=STATUS_OFS, reg_rd=1 for one cycle. POLL_CHK: sample reg_dout.
  - If reg_dout[BUSY_BIT]=0 -> DONE, err=0.
  - Else increment the 16-bit poll counter. If it equals POLL_MAX -> DONE, err=1; otherwise -> POLL_WAIT.
- DONE: seq_done=1 for one cycle -> IDLE.
- seq_rdy=1 only in IDLE. A seq_req while busy is ignored and not queued.
- reg_wr and reg_rd are never high together. Outside a strobe cycle, reg_addr and reg_din are 0.

## Timing

- Reset values: seq_rdy=1, seq_done=0, seq_err=0, reg_addr=0, reg_wr=0, reg_rd=0, reg_din=0; state IDLE; counters 0.
- Accept in cycle 0. Write k strobes in cycle 1+2k, so CMD is in cycle 1 and CTRL0 in cycle 25. seq_rdy drops in cycle 1.
- POLL_WAIT occupies cycles 26..25+POLL_GAP. First reg_rd is in cycle 26+POLL_GAP. Sample is in cycle 27+POLL_GAP.
- Ready on first poll: seq_done in cycle 28+POLL_GAP; seq_rdy=1 the cycle after.
- Each extra busy poll adds POLL_GAP+2 cycles.
- The back-to-back accept is earliest in the cycle after seq_done.
- Asserting rst_nfc mid-sequence drops any strobe immediately and returns to IDLE with all outputs at reset values. No partial write completes after deassertion.

## Test plan

- Reset mid-write: assert rst_nfc during cycle 9 -> reg_wr=0 the same cycle; seq_rdy=1 after release; no further strobes.
- Nominal write sequence: cmd=8'h70, row=32'h55CC2200, col=32'h00AA0302, addr_cnt=8'h1A, timing=8'h36, trn=8'h10, ctrl0=8'hC9, status not busy -> 13 writes in the listed order (row0 00/22/CC/55, col0 02/03/AA/00, ctrl0 C9 last) on odd cycles 1..25; one read of STATUS_OFS; seq_done in cycle 36 (POLL_GAP=8) with err=0.
- Busy then ready: status busy for 3 polls, then clear -> 4 reg_rd pulses spaced 10 cycles apart; seq_done=1, err=0.
- Timeout: POLL_MAX=4, status always busy -> exactly 4 reads; seq_done with seq_err=1; seq_err stays high until the next accept.
- Request while busy: seq_req held high throughout -> second operation is accepted only in the cycle after seq_done; there is no overlap of strobes.
